// File: rtl/cpuDefine_pkg.sv
// Shared CPU types and writeback-stage constants.
package cpuDefine;
  localparam int rfNum        = 32;
  localparam int WB_SRC_NUM   = 3;
  localparam int STARVE_LIMIT = 4;

  typedef logic [$clog2(rfNum)-1:0] Gr;
  typedef logic [31:0]              DType;

  typedef enum logic [1:0] {
    WB_LSU = 2'd0,
    WB_MDU = 2'd1,
    WB_ALU = 2'd2
  } wb_src_e;
endpackage

// File: rtl/wb_arbiter.sv
// Single-grant writeback arbiter: fixed low-index priority, with anti-starvation
// promotion for every source from WB_MDU upward.
module wb_arbiter
  import cpuDefine::*;
#(
  parameter int N     = cpuDefine::WB_SRC_NUM,
  parameter int LIMIT = cpuDefine::STARVE_LIMIT
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         flush,
  input  logic [N-1:0] src_valid,
  output logic [N-1:0] src_ready
);
  localparam int FIRST = int'(WB_MDU);
  localparam int CW    = $clog2(LIMIT + 1);

  logic [N-1:FIRST][CW-1:0] starve_cnt;
  logic                     found;

  // Starved sources win first (lowest index among them), then plain priority.
  always_comb begin
    src_ready = '0;
    found     = 1'b0;
    for (int i = FIRST; i < N; i++) begin
      if (!found && src_valid[i] && starve_cnt[i] == CW'(LIMIT)) begin
        src_ready[i] = 1'b1;
        found        = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && src_valid[i]) begin
        src_ready[i] = 1'b1;
        found        = 1'b1;
      end
    end
    if (reset || flush) src_ready = '0;
  end

  always_ff @(posedge aclk) begin
    if (reset || flush) begin
      starve_cnt <= '0;
    end else begin
      for (int i = FIRST; i < N; i++) begin
        if (src_valid[i] && !src_ready[i]) begin
          if (starve_cnt[i] != CW'(LIMIT)) starve_cnt[i] <= starve_cnt[i] + CW'(1);
        end else begin
          starve_cnt[i] <= '0;
        end
      end
    end
  end
endmodule

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates result sources into one register-file write per
// cycle and tracks outstanding destination registers.
module wb_unit
  import cpuDefine::*;
#(
  parameter int STARVE_LIMIT = cpuDefine::STARVE_LIMIT,
  parameter int WB_SRC_NUM   = cpuDefine::WB_SRC_NUM
) (
  input  logic                             aclk,
  input  logic                             reset,
  input  logic [WB_SRC_NUM-1:0]            src_valid,
  output logic [WB_SRC_NUM-1:0]            src_ready,
  input  logic [WB_SRC_NUM-1:0][4:0]       src_rd,
  input  logic [WB_SRC_NUM-1:0][31:0]      src_data,
  input  logic                             issue_en,
  input  logic [4:0]                       issue_rd,
  input  logic                             flush,
  output logic [4:0]                       rd_wb_out,
  output logic                             regWriteEn,
  output logic [31:0]                      regWriteData,
  output logic [rfNum-1:0]                 pending,
  output logic [31:0]                      wb_count
);
  logic             acc;
  Gr                sel_rd;
  DType             sel_data;
  logic [rfNum-1:0] pend_nxt;

  wb_arbiter #(.N(WB_SRC_NUM), .LIMIT(STARVE_LIMIT)) u_arb (
    .aclk      (aclk),
    .reset     (reset),
    .flush     (flush),
    .src_valid (src_valid),
    .src_ready (src_ready)
  );

  always_comb begin
    acc      = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < WB_SRC_NUM; i++) begin
      if (src_ready[i]) begin
        acc      = 1'b1;
        sel_rd   = src_rd[i];
        sel_data = src_data[i];
      end
    end
  end

  // Issue is applied after the clear so a same-cycle set wins; flush beats both.
  always_comb begin
    pend_nxt = pending;
    if (acc)      pend_nxt[sel_rd]   = 1'b0;
    if (issue_en) pend_nxt[issue_rd] = 1'b1;
    if (flush)    pend_nxt           = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      regWriteEn   <= 1'b0;
      rd_wb_out    <= '0;
      regWriteData <= '0;
      pending      <= '0;
      wb_count     <= '0;
    end else begin
      regWriteEn <= acc && (sel_rd != '0);
      if (acc && (sel_rd != '0)) begin
        rd_wb_out    <= sel_rd;
        regWriteData <= sel_data;
      end
      pending  <= pend_nxt;
      wb_count <= wb_count + {31'b0, regWriteEn};
    end
  end
endmodule

// File: tb/tb_wb_unit.sv
// Directed + random bench for wb_unit against a cycle-level behavioural model.
module tb_wb_unit;
  localparam int LIM = 4;

  logic              aclk = 1'b0;
  logic              reset;
  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [2:0][4:0]   src_rd;
  logic [2:0][31:0]  src_data;
  logic              issue_en;
  logic [4:0]        issue_rd;
  logic              flush;
  logic [4:0]        rd_wb_out;
  logic              regWriteEn;
  logic [31:0]       regWriteData;
  logic [31:0]       pending;
  logic [31:0]       wb_count;

  int total = 0;
  int bad   = 0;

  // model state
  int         starve [3];
  bit [31:0]  m_pend;
  bit         m_we;
  bit [4:0]   m_rd;
  bit [31:0]  m_data;
  bit [31:0]  m_cnt;

  always #5 aclk = ~aclk;

  wb_unit #(.STARVE_LIMIT(LIM), .WB_SRC_NUM(3)) dut (
    .aclk(aclk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .issue_en(issue_en), .issue_rd(issue_rd),
    .flush(flush), .rd_wb_out(rd_wb_out), .regWriteEn(regWriteEn),
    .regWriteData(regWriteData), .pending(pending), .wb_count(wb_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Who should win: any starved MDU/ALU (MDU first), else lowest valid index.
  function automatic int pick(input logic [2:0] v);
    for (int i = 1; i < 3; i++) if (v[i] && starve[i] == LIM) return i;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cycle(input logic [2:0] v, input logic [2:0][4:0] rd,
                       input logic [2:0][31:0] d, input logic ie, input logic [4:0] ir,
                       input logic fl, input logic rs);
    int p;
    logic [2:0] er;
    src_valid = v; src_rd = rd; src_data = d;
    issue_en = ie; issue_rd = ir; flush = fl; reset = rs;
    #1;
    p  = (rs || fl) ? -1 : pick(v);
    er = (p < 0) ? 3'b000 : 3'(1 << p);
    chk("ready", 32'(src_ready), 32'(er));
    if (rs) begin
      m_we = 0; m_rd = 0; m_data = 0; m_pend = 0; m_cnt = 0;
      starve[1] = 0; starve[2] = 0;
    end else begin
      m_cnt = m_cnt + 32'(m_we);
      m_we  = 0;
      if (p >= 0 && rd[p] != 0) begin
        m_we = 1; m_rd = rd[p]; m_data = d[p];
      end
      if (fl) m_pend = 0;
      else begin
        if (p >= 0) m_pend[rd[p]] = 1'b0;
        if (ie)     m_pend[ir]    = 1'b1;
        m_pend[0] = 1'b0;
      end
      for (int i = 1; i < 3; i++)
        starve[i] = (!fl && v[i] && p != i) ? ((starve[i] + 1 > LIM) ? LIM : starve[i] + 1) : 0;
    end
    @(posedge aclk);
    #1;
    chk("we",    32'(regWriteEn), 32'(m_we));
    chk("rd",    32'(rd_wb_out),  32'(m_rd));
    chk("data",  regWriteData,    m_data);
    chk("pend",  pending,         m_pend);
    chk("count", wb_count,        m_cnt);
  endtask

  initial begin
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] d;
    starve[0] = 0; starve[1] = 0; starve[2] = 0;
    m_pend = 0; m_we = 0; m_rd = 0; m_data = 0; m_cnt = 0;
    src_valid = 0; src_rd = 0; src_data = 0; issue_en = 0; issue_rd = 0;
    flush = 0; reset = 1;
    @(posedge aclk); #1;
    cycle(3'b000, '0, '0, 0, 0, 0, 1);
    cycle(3'b000, '0, '0, 0, 0, 0, 1);
    chk("rst_count", wb_count, 32'h0);
    chk("rst_pend",  pending,  32'h0);

    // LSU beats ALU, ALU follows
    rd = {5'd5, 5'd0, 5'd3}; d = {32'h22, 32'h0, 32'h11};
    cycle(3'b101, rd, d, 0, 0, 0, 0);
    chk("r3_rd", 32'(rd_wb_out), 32'd3);
    chk("r3_data", regWriteData, 32'h11);
    cycle(3'b100, rd, d, 0, 0, 0, 0);
    chk("r5_rd", 32'(rd_wb_out), 32'd5);
    cycle(3'b000, rd, d, 0, 0, 0, 0);

    // ALU starvation promotion
    rd = {5'd6, 5'd0, 5'd1};
    for (int k = 0; k < 5; k++) begin
      d = {32'hA1, 32'h0, 32'(k)};
      cycle(3'b101, rd, d, 0, 0, 0, 0);
    end
    chk("starve_rd", 32'(rd_wb_out), 32'd6);
    chk("starve_data", regWriteData, 32'hA1);
    cycle(3'b101, rd, d, 0, 0, 0, 0);
    chk("starve_clr", 32'(rd_wb_out), 32'd1);

    // pending set wins over same-cycle clear
    cycle(3'b000, '0, '0, 1, 5'd7, 0, 0);
    cycle(3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h77, 32'h0}, 1, 5'd7, 0, 0);
    chk("p7", 32'(pending[7]), 32'd1);
    chk("p7_rd", 32'(rd_wb_out), 32'd7);

    // rd=0 is accepted but not written
    cycle(3'b100, '0, {32'hDEAD, 32'h0, 32'h0}, 0, 0, 0, 0);
    chk("rd0_we", 32'(regWriteEn), 32'd0);

    // flush with a write in flight
    cycle(3'b000, '0, '0, 0, 0, 1, 0);
    for (int r = 4; r < 8; r++) cycle(3'b000, '0, '0, 1, 5'(r), 0, 0);
    chk("pend_f0", pending, 32'h0000_00F0);
    cycle(3'b001, {5'd0, 5'd0, 5'd9}, {32'h0, 32'h0, 32'h99}, 0, 0, 0, 0);
    cycle(3'b001, {5'd0, 5'd0, 5'd10}, {32'h0, 32'h0, 32'h10}, 0, 0, 1, 0);
    chk("fl_pend", pending, 32'h0);
    chk("fl_we", 32'(regWriteEn), 32'd0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        rd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        d[i]  = $urandom;
      end
      cycle(3'($urandom | ($urandom_range(0, 1) ? 32'h5 : 32'h0)), rd, d,
            1'($urandom), 5'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
    end

    // wb_count wrap
    cycle(3'b001, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h2}, 0, 0, 0, 0);
    force dut.wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    m_cnt = 32'hFFFF_FFFF;
    cycle(3'b000, '0, '0, 0, 0, 0, 0);
    chk("wrap", wb_count, 32'h0);

    // reset while a result is in flight
    cycle(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h33}, 1, 5'd8, 0, 0);
    cycle(3'b001, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h0, 32'h44}, 0, 0, 0, 1);
    chk("rst_we", 32'(regWriteEn), 32'd0);
    chk("rst_data", regWriteData, 32'h0);
    cycle(3'b000, '0, '0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
